// File: rtl/control_unit_if.sv
// Bus/control bundle between the instruction sequencer and the datapath.
// master = sequencer side (drives control lines), slave = datapath/stimulus side.
interface control_unit_if;
    logic       Run;
    logic [8:0] DIN;
    logic [7:0] Rout;
    logic       Gout;
    logic       DINout;
    logic       Bout;
    logic       Fout;
    logic [7:0] Rin;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       Done;
    logic [8:0] IR;

    modport master (
        input  Run, DIN,
        output Rout, Gout, DINout, Bout, Fout, Rin, Ain, Gin, AddSub, Done, IR
    );

    modport slave (
        output Run, DIN,
        input  Rout, Gout, DINout, Bout, Fout, Rin, Ain, Gin, AddSub, Done, IR
    );
endinterface

// File: rtl/control_unit.sv
// Four-step instruction sequencer: fetches a 9-bit instruction into IR on Run
// and steps T0..T3, decoding bus-select and load enables from state and IR.
module control_unit (
    input  logic          Clock,
    input  logic          Resetn,
    control_unit_if.master bus
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MVB  = 3'b100,
        OP_MVF  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } opcode_t;

    state_t     r_state;
    state_t     w_next;
    logic [8:0] r_ir;

    opcode_t    w_op;
    logic [7:0] w_x_oh;
    logic [7:0] w_y_oh;

    logic [7:0] w_rout;
    logic       w_gout;
    logic       w_dinout;
    logic       w_bout;
    logic       w_fout;
    logic [7:0] w_rin;
    logic       w_ain;
    logic       w_gin;
    logic       w_addsub;
    logic       w_done;

    assign w_op   = opcode_t'(r_ir[8:6]);
    assign w_x_oh = 8'd1 << r_ir[5:3];
    assign w_y_oh = 8'd1 << r_ir[2:0];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= T0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == T0 && bus.Run)
                r_ir <= bus.DIN;
        end
    end

    // Run only steers the next state; every control output decodes state and IR alone.
    always_comb begin
        w_next   = T0;
        w_rout   = '0;
        w_gout   = 1'b0;
        w_dinout = 1'b0;
        w_bout   = 1'b0;
        w_fout   = 1'b0;
        w_rin    = '0;
        w_ain    = 1'b0;
        w_gin    = 1'b0;
        w_addsub = 1'b0;
        w_done   = 1'b0;

        case (r_state)
            T0: begin
                w_next = bus.Run ? T1 : T0;
            end

            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_rout = w_y_oh;
                        w_rin  = w_x_oh;
                        w_done = 1'b1;
                    end
                    OP_MVI: begin
                        w_dinout = 1'b1;
                        w_rin    = w_x_oh;
                        w_done   = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_rout = w_x_oh;
                        w_ain  = 1'b1;
                        w_next = T2;
                    end
                    OP_MVB: begin
                        w_bout = 1'b1;
                        w_rin  = w_x_oh;
                        w_done = 1'b1;
                    end
                    OP_MVF: begin
                        w_fout = 1'b1;
                        w_rin  = w_x_oh;
                        w_done = 1'b1;
                    end
                    default: begin
                        w_done = 1'b1;
                    end
                endcase
            end

            T2: begin
                if (w_op == OP_ADD || w_op == OP_SUB) begin
                    w_rout   = w_y_oh;
                    w_gin    = 1'b1;
                    w_addsub = r_ir[6];
                    w_next   = T3;
                end
            end

            T3: begin
                if (w_op == OP_ADD || w_op == OP_SUB) begin
                    w_gout = 1'b1;
                    w_rin  = w_x_oh;
                    w_done = 1'b1;
                end
            end

            default: begin
                w_next = T0;
            end
        endcase
    end

    assign bus.Rout   = w_rout;
    assign bus.Gout   = w_gout;
    assign bus.DINout = w_dinout;
    assign bus.Bout   = w_bout;
    assign bus.Fout   = w_fout;
    assign bus.Rin    = w_rin;
    assign bus.Ain    = w_ain;
    assign bus.Gin    = w_gin;
    assign bus.AddSub = w_addsub;
    assign bus.Done   = w_done;
    assign bus.IR     = r_ir;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: hand-computed control vectors per step,
// plus a per-cycle bus-exclusivity / one-hot monitor.
module tb_control_unit;

    logic Clock;
    logic Resetn;

    control_unit_if bus ();

    control_unit dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_prev = -1;
    int done_last = -1;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // {Rout[23:16], Gout, DINout, Bout, Fout, Rin[11:4], Ain, Gin, AddSub, Done}
    function automatic logic [23:0] ctrl_vec();
        return {bus.Rout, bus.Gout, bus.DINout, bus.Bout, bus.Fout,
                bus.Rin, bus.Ain, bus.Gin, bus.AddSub, bus.Done};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // At most one bus driver, Rout/Rin zero or one-hot; also log Done cycles.
    always @(negedge Clock) begin
        if (Resetn) begin
            n_tests++;
            assert ($countones({|bus.Rout, bus.Gout, bus.DINout, bus.Bout, bus.Fout}) <= 1
                    && $onehot0(bus.Rout) && $onehot0(bus.Rin))
            else begin
                n_fail++;
                $error("FAIL bus_excl: observed Rout=%h G=%b DIN=%b B=%b F=%b Rin=%h expected exclusive/onehot0",
                       bus.Rout, bus.Gout, bus.DINout, bus.Bout, bus.Fout, bus.Rin);
            end
            if (bus.Done) begin
                done_prev = done_last;
                done_last = cyc;
            end
        end
    end

    initial begin
        #20000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Resetn  = 1'b0;
        bus.Run = 1'b0;
        bus.DIN = '0;
        #2;
        chk("reset_ctrl", 32'(ctrl_vec()), 32'h0);
        chk("reset_ir",   32'(bus.IR),     32'h0);
        step();
        step();
        Resetn = 1'b1;
        step();
        chk("idle_ctrl", 32'(ctrl_vec()), 32'h0);
        step();
        chk("idle_ir",   32'(bus.IR),     32'h0);

        // mvi R3,#5
        bus.Run = 1'b1; bus.DIN = 9'b001_011_000;
        step();
        bus.Run = 1'b0; bus.DIN = 9'h005;
        chk("mvi_ir",  32'(bus.IR),     32'h058);
        chk("mvi_t1",  32'(ctrl_vec()), 32'h004081);
        step();
        chk("mvi_t0",  32'(ctrl_vec()), 32'h0);
        chk("mvi_irk", 32'(bus.IR),     32'h058);

        // mv R2,R5
        bus.Run = 1'b1; bus.DIN = 9'b000_010_101;
        step();
        bus.Run = 1'b0;
        chk("mv_t1", 32'(ctrl_vec()), 32'h200041);
        step();
        chk("mv_t0", 32'(ctrl_vec()), 32'h0);

        // sub R1,R6 ; DIN change during T1 must be ignored
        bus.Run = 1'b1; bus.DIN = 9'b011_001_110;
        step();
        bus.Run = 1'b1; bus.DIN = 9'h1FF;
        chk("sub_t1", 32'(ctrl_vec()), 32'h020008);
        bus.Run = 1'b0;
        step();
        chk("sub_t2", 32'(ctrl_vec()), 32'h400006);
        step();
        chk("sub_t3", 32'(ctrl_vec()), 32'h008021);
        step();
        chk("sub_t0", 32'(ctrl_vec()), 32'h0);
        chk("sub_ir", 32'(bus.IR),     32'h0CE);

        // add R3,R3 (X=Y)
        bus.Run = 1'b1; bus.DIN = 9'b010_011_011;
        step();
        bus.Run = 1'b0;
        chk("addxx_t1", 32'(ctrl_vec()), 32'h080008);
        step();
        chk("addxx_t2", 32'(ctrl_vec()), 32'h080004);
        step();
        chk("addxx_t3", 32'(ctrl_vec()), 32'h008081);
        step();

        // mvb R7, mvf R7, reserved 111
        bus.Run = 1'b1; bus.DIN = 9'b100_111_000;
        step();
        bus.Run = 1'b0;
        chk("mvb_t1", 32'(ctrl_vec()), 32'h002801);
        step();
        bus.Run = 1'b1; bus.DIN = 9'b101_111_000;
        step();
        bus.Run = 1'b0;
        chk("mvf_t1", 32'(ctrl_vec()), 32'h001801);
        step();
        bus.Run = 1'b1; bus.DIN = 9'b111_111_000;
        step();
        bus.Run = 1'b0;
        chk("rsv_t1", 32'(ctrl_vec()), 32'h000001);
        step();
        chk("rsv_t0", 32'(ctrl_vec()), 32'h0);

        // add R1,R2 aborted by reset in T2
        bus.Run = 1'b1; bus.DIN = 9'b010_001_010;
        step();
        bus.Run = 1'b0;
        chk("abort_t1", 32'(ctrl_vec()), 32'h020008);
        step();
        chk("abort_t2", 32'(ctrl_vec()), 32'h040004);
        #2;
        Resetn = 1'b0;
        #1;
        chk("abort_ctrl", 32'(ctrl_vec()), 32'h0);
        chk("abort_ir",   32'(bus.IR),     32'h0);
        step();
        chk("abort_hold", 32'(ctrl_vec()), 32'h0);
        Resetn = 1'b1;
        step();
        chk("post_rst_idle", 32'(ctrl_vec()), 32'h0);
        chk("post_rst_ir",   32'(bus.IR),     32'h0);
        bus.Run = 1'b1; bus.DIN = 9'b001_000_000;
        step();
        bus.Run = 1'b0;
        chk("post_rst_fetch", 32'(ctrl_vec()), 32'h004011);
        step();

        // Run held high across two mvi: R2 then R5 (DIN change during T1 ignored)
        bus.Run = 1'b1; bus.DIN = 9'b001_010_000;
        step();
        bus.DIN = 9'b001_101_000;
        chk("b2b_1",    32'(ctrl_vec()), 32'h004041);
        step();
        chk("b2b_t0",   32'(ctrl_vec()), 32'h0);
        chk("b2b_t0ir", 32'(bus.IR),     32'h050);
        step();
        bus.Run = 1'b0;
        chk("b2b_2",    32'(ctrl_vec()), 32'h004201);
        chk("b2b_2ir",  32'(bus.IR),     32'h068);
        step();
        chk("b2b_gap",  32'(done_last - done_prev), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port Resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Run, input, 1, start request; sampled only in state T0.
REQ-004 SHALL have port DIN, input, 9, instruction word source for the internal IR.
REQ-005 SHALL have port Rout, output, 8, one-hot register-to-bus select (bit i selects Ri).
REQ-006 SHALL have ports Gout, DINout, Bout, Fout, output, 1 each, bus select for G, DIN, B, F.
REQ-007 SHALL have port Rin, output, 8, one-hot register load enable (bit i loads Ri).
REQ-008 SHALL have ports Ain, Gin, AddSub, output, 1 each; A load, G load, ALU op (0 add, 1 sub).
REQ-009 SHALL have port Done, output, 1, high for exactly the final cycle of each instruction.
REQ-010 SHALL have port IR, output, 9, current instruction register contents.

Function
REQ-011 SHALL implement a 4-state FSM: T0 (fetch/idle), T1, T2, T3.
REQ-012 SHALL decode IR as III = IR[8:6] opcode, XXX = IR[5:3] destination index, YYY = IR[2:0] source index.
REQ-013 SHALL hold all control outputs at 0 in every state/opcode combination not listed below.
REQ-014 SHALL ensure that at most one of Rout, Gout, DINout, Bout, Fout is nonzero in any cycle, and that Rout/Rin are always zero or one-hot.
REQ-015 T0: Run=1 SHALL load IR from DIN at the clock edge and go to T1; Run=0 SHALL stay in T0 with IR unchanged; Done=0.
REQ-016 Opcode 000 (mv Rx,Ry), T1: Rout=onehot(Y), Rin=onehot(X), Done=1, next state T0.
REQ-017 Opcode 001 (mvi Rx,#D), T1: DINout=1, Rin=onehot(X), Done=1, next state T0.
REQ-018 Opcode 010/011 (add/sub Rx,Ry), T1: Rout=onehot(X), Ain=1, next state T2.
REQ-019 Opcode 010/011, T2: Rout=onehot(Y), Gin=1, AddSub=IR[6], next state T3.
REQ-020 Opcode 010/011, T3: Gout=1, Rin=onehot(X), Done=1, next state T0.
REQ-021 Opcode 100 (mvb Rx), T1: Bout=1, Rin=onehot(X), Done=1, next state T0.
REQ-022 Opcode 101 (mvf Rx), T1: Fout=1, Rin=onehot(X), Done=1, next state T0.
REQ-023 Opcodes 110/111 (reserved), T1: no bus select, no load, Done=1, next state T0.
REQ-024 Latency from the Run edge to Done: 1 cycle for all opcodes except add/sub, which take 3 cycles.
REQ-025 X=Y SHALL be legal: for mv this is a self-copy; for add it computes Rx+Rx.
REQ-026 Run held high SHALL make a new fetch in the T0 cycle immediately after Done, with no bubble cycle.
REQ-027 Run and DIN changes outside T0 SHALL be ignored.
REQ-028 All control outputs SHALL be combinational decodes of the state register and IR only; they SHALL NOT depend on Run.
REQ-029 Illegal state encodings SHALL return to T0 on the next edge with outputs 0.

Reset
REQ-030 Resetn=0 SHALL immediately and asynchronously force state T0, IR=9'h000, and all control outputs 0.
REQ-031 Reset asserted mid-instruction (T1-T3) SHALL abort it; no Rin/Gin/Ain pulse SHALL occur after assertion.
REQ-032 After Resetn deasserts, the first fetch SHALL occur on the first edge with Run=1.

Verification
REQ-033 Scenario mvi: Run=1, DIN=9'b001_011_000, then DIN=9'h05 -> in T1, DINout=1, Rin=8'h08, Done=1; next cycle T0.
REQ-034 Scenario mv: DIN=9'b000_010_101 -> in T1, Rout=8'h20, Rin=8'h04, Done=1.
REQ-035 Scenario sub: DIN=9'b011_001_110 -> T1 Rout=8'h02/Ain=1; T2 Rout=8'h40/Gin=1/AddSub=1; T3 Gout=1/Rin=8'h02/Done=1.
REQ-036 Scenario B/F/reserved: opcodes 100, 101, 111 with X=7 -> Bout=1 with Rin=8'h80; Fout=1 with Rin=8'h80; Done=1 only with Rin=0.
REQ-037 Scenario reset mid-op: Resetn low during T2 of add -> outputs 0 and IR=0 in the same cycle; Done is never asserted for that instruction.
REQ-038 Scenario back-to-back: Run held high across two mvi instructions -> Done pulses 2 cycles apart; every cycle meets REQ-014, checked by assertion.
